// File: rtl/hex_center_pixel_q16_if.sv
// Beat bus for hex_center_pixel_q16: upstream fractional cube coords in,
// rounded hex and its Q16.16 pixel center out, valid/ready on both sides.
interface hex_center_pixel_q16_if;
    // Upstream side
    logic               valid_in;
    logic               ready_out;
    logic signed [31:0] q_f;
    logic signed [31:0] r_f;
    logic signed [31:0] s_f;
    logic signed [31:0] hex_size_q16;
    logic signed [31:0] origin_x_q16;
    logic signed [31:0] origin_y_q16;

    // Downstream side
    logic               valid_out;
    logic               ready_in;
    logic signed [15:0] q_i;
    logic signed [15:0] r_i;
    logic signed [31:0] x_q16;
    logic signed [31:0] y_q16;

    // Environment view: produces beats and consumes results
    modport master (
        output valid_in, q_f, r_f, s_f, hex_size_q16, origin_x_q16, origin_y_q16,
        input  ready_out,
        input  valid_out, q_i, r_i, x_q16, y_q16,
        output ready_in
    );

    // Block view
    modport slave (
        input  valid_in, q_f, r_f, s_f, hex_size_q16, origin_x_q16, origin_y_q16,
        output ready_out,
        output valid_out, q_i, r_i, x_q16, y_q16,
        input  ready_in
    );
endinterface

// File: rtl/hex_center_pixel_q16.sv
// Cube-rounds fractional Q16.16 hex coordinates to the owning hex and returns
// that hex's pointy-top center in Q16.16 world space (scaled, offset, saturated).
// Three register stages sharing one global enable; bubbles travel with the pipe.
module hex_center_pixel_q16 (
    input  logic                  clk,
    input  logic                  reset,
    hex_center_pixel_q16_if.slave bus
);
    localparam int unsigned CW = 32;   // Q16.16 word
    localparam int unsigned HW = 16;   // integer hex coordinate
    localparam int unsigned EW = 34;   // rounding error magnitude
    localparam int unsigned UW = 40;   // unit-size center
    localparam int unsigned PW = 73;   // scaled product + origin

    localparam logic signed [UW-1:0] SQRT3       = 40'sd113512;
    localparam logic signed [UW-1:0] SQRT3_DIV_2 = 40'sd56756;
    localparam logic signed [UW-1:0] THREE_DIV_2 = 40'sd98304;

    // Round half toward +inf, keeping the low 16 integer bits
    function automatic logic signed [HW-1:0] round_q16(input logic signed [CW-1:0] c);
        logic signed [CW:0] sum;
        sum = {c[CW-1], c} + 33'sd32768;
        return sum[CW-1:16];
    endfunction

    // Distance between a rounded component and its fractional source
    function automatic logic [EW-1:0] err_q16(input logic signed [CW-1:0] c,
                                               input logic signed [HW-1:0] rc);
        logic signed [EW-1:0] diff;
        diff = {{(EW-CW){rc[HW-1]}}, rc, 16'b0} - {{(EW-CW){c[CW-1]}}, c};
        return diff[EW-1] ? EW'(-diff) : EW'(diff);
    endfunction

    // Clamp a wide signed result into the signed 32-bit range
    function automatic logic signed [CW-1:0] sat32(input logic signed [PW-1:0] v);
        logic [PW-CW:0] top;
        top = v[PW-1:CW-1];
        if (&top || ~|top) begin
            return v[CW-1:0];
        end
        return v[PW-1] ? 32'sh80000000 : 32'sh7FFFFFFF;
    endfunction

    logic en;

    logic signed [HW-1:0] rq_raw, rr_raw, rs_raw;
    logic        [EW-1:0] dq, dr, ds;
    logic signed [HW-1:0] rq_c, rr_c;

    logic                 s1_v;
    logic signed [HW-1:0] s1_rq, s1_rr;
    logic signed [CW-1:0] s1_size, s1_ox, s1_oy;

    logic signed [UW-1:0] xu_c, yu_c;

    logic                 s2_v;
    logic signed [HW-1:0] s2_rq, s2_rr;
    logic signed [UW-1:0] s2_xu, s2_yu;
    logic signed [CW-1:0] s2_size, s2_ox, s2_oy;

    logic signed [PW-1:0] px_c, py_c, sx_c, sy_c;

    // Whole pipe moves when the output slot is empty or being drained
    assign en            = !bus.valid_out || bus.ready_in;
    assign bus.ready_out = en;

    // Stage 1: per-component round and error terms
    always_comb begin
        rq_raw = round_q16(bus.q_f);
        rr_raw = round_q16(bus.r_f);
        rs_raw = round_q16(bus.s_f);
        dq     = err_q16(bus.q_f, rq_raw);
        dr     = err_q16(bus.r_f, rr_raw);
        ds     = err_q16(bus.s_f, rs_raw);
    end

    // Stage 1: fix the component with the largest error so q + r + s = 0
    always_comb begin
        rq_c = rq_raw;
        rr_c = rr_raw;
        if (dq > dr && dq > ds) begin
            rq_c = -rr_raw - rs_raw;
        end else if (dr > ds) begin
            rr_c = -rq_raw - rs_raw;
        end
    end

    // Stage 1 register: rounded hex plus the per-beat scale and origin
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v    <= 1'b0;
            s1_rq   <= '0;
            s1_rr   <= '0;
            s1_size <= '0;
            s1_ox   <= '0;
            s1_oy   <= '0;
        end else if (en) begin
            s1_v    <= bus.valid_in;
            s1_rq   <= rq_c;
            s1_rr   <= rr_c;
            s1_size <= bus.hex_size_q16;
            s1_ox   <= bus.origin_x_q16;
            s1_oy   <= bus.origin_y_q16;
        end
    end

    // Stage 2: unit-size pointy-top center
    always_comb begin
        xu_c = SQRT3 * UW'(s1_rq) + SQRT3_DIV_2 * UW'(s1_rr);
        yu_c = THREE_DIV_2 * UW'(s1_rr);
    end

    // Stage 2 register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_v    <= 1'b0;
            s2_rq   <= '0;
            s2_rr   <= '0;
            s2_xu   <= '0;
            s2_yu   <= '0;
            s2_size <= '0;
            s2_ox   <= '0;
            s2_oy   <= '0;
        end else if (en) begin
            s2_v    <= s1_v;
            s2_rq   <= s1_rq;
            s2_rr   <= s1_rr;
            s2_xu   <= xu_c;
            s2_yu   <= yu_c;
            s2_size <= s1_size;
            s2_ox   <= s1_ox;
            s2_oy   <= s1_oy;
        end
    end

    // Stage 3: scale by hex size, drop the extra fraction, add origin
    always_comb begin
        px_c = PW'(s2_xu) * PW'(s2_size);
        py_c = PW'(s2_yu) * PW'(s2_size);
        sx_c = (px_c >>> 16) + PW'(s2_ox);
        sy_c = (py_c >>> 16) + PW'(s2_oy);
    end

    // Stage 3 register: saturated outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.valid_out <= 1'b0;
            bus.q_i       <= '0;
            bus.r_i       <= '0;
            bus.x_q16     <= '0;
            bus.y_q16     <= '0;
        end else if (en) begin
            bus.valid_out <= s2_v;
            bus.q_i       <= s2_rq;
            bus.r_i       <= s2_rr;
            bus.x_q16     <= sat32(sx_c);
            bus.y_q16     <= sat32(sy_c);
        end
    end
endmodule

// File: tb/tb_hex_center_pixel_q16.sv
// Bench for hex_center_pixel_q16: directed beats with literal expectations,
// plus a scoreboard fed by an arithmetic model of cube rounding and hex centers.
module tb_hex_center_pixel_q16;
    logic clk = 1'b0;
    logic reset;

    hex_center_pixel_q16_if bus ();

    hex_center_pixel_q16 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [15:0] q;
        logic signed [15:0] r;
        logic signed [31:0] x;
        logic signed [31:0] y;
    } res_t;

    int   n_total = 0;
    int   n_bad   = 0;
    int   n_out   = 0;
    res_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Hex owning a fractional cube point, and its scaled, offset, clamped center
    function automatic res_t model(input int qf, input int rf, input int sf,
                                   input int sz, input int ox, input int oy);
        longint c[3];
        longint rc[3];
        longint d[3];
        int     h[3];
        logic signed [127:0] qb, rb, xu, yu, px, py;
        res_t o;
        c[0] = qf; c[1] = rf; c[2] = sf;
        for (int i = 0; i < 3; i++) begin
            rc[i] = (c[i] + 64'sd32768) >>> 16;
            d[i]  = rc[i] * 65536 - c[i];
            if (d[i] < 0) d[i] = -d[i];
            h[i]  = int'(rc[i]);
        end
        if (d[0] > d[1] && d[0] > d[2]) h[0] = -h[1] - h[2];
        else if (d[1] > d[2])           h[1] = -h[0] - h[2];
        o.q = 16'(h[0]);
        o.r = 16'(h[1]);
        qb = o.q;
        rb = o.r;
        xu = qb * 113512 + rb * 56756;
        yu = rb * 98304;
        px = ((xu * sz) >>> 16) + ox;
        py = ((yu * sz) >>> 16) + oy;
        if (px > 128'sd2147483647)       o.x = 32'sh7FFFFFFF;
        else if (px < -128'sd2147483648) o.x = 32'sh80000000;
        else                             o.x = px[31:0];
        if (py > 128'sd2147483647)       o.y = 32'sh7FFFFFFF;
        else if (py < -128'sd2147483648) o.y = 32'sh80000000;
        else                             o.y = py[31:0];
        return o;
    endfunction

    // Compare process: records accepted beats, checks consumed ones and stall stability
    logic hold_v = 1'b0;
    res_t held;
    always @(negedge clk) begin
        res_t e;
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall_valid", 32'(bus.valid_out), 32'd1);
                check("stall_q", 32'(bus.q_i), 32'(held.q));
                check("stall_r", 32'(bus.r_i), 32'(held.r));
                check("stall_x", bus.x_q16, held.x);
                check("stall_y", bus.y_q16, held.y);
            end
            check("ready_rule", 32'(bus.ready_out), 32'(!bus.valid_out || bus.ready_in));
            if (bus.valid_in && bus.ready_out)
                exp_q.push_back(model(bus.q_f, bus.r_f, bus.s_f, bus.hex_size_q16,
                                      bus.origin_x_q16, bus.origin_y_q16));
            if (bus.valid_out && bus.ready_in) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got q=%0d r=%0d required none",
                             bus.q_i, bus.r_i);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_q", 32'(bus.q_i), 32'(e.q));
                    check("sb_r", 32'(bus.r_i), 32'(e.r));
                    check("sb_x", bus.x_q16, e.x);
                    check("sb_y", bus.y_q16, e.y);
                end
                n_out++;
            end
            hold_v = bus.valid_out && !bus.ready_in;
            held.q = bus.q_i;
            held.r = bus.r_i;
            held.x = bus.x_q16;
            held.y = bus.y_q16;
        end
    end

    task automatic set_beat(input int qf, input int rf, input int sf,
                            input int sz, input int ox, input int oy);
        bus.q_f          = qf;
        bus.r_f          = rf;
        bus.s_f          = sf;
        bus.hex_size_q16 = sz;
        bus.origin_x_q16 = ox;
        bus.origin_y_q16 = oy;
        bus.valid_in     = 1'b1;
    endtask

    // One beat into an idle pipe; checks latency and hand-computed results
    task automatic single(input string name, input int qf, input int rf, input int sf,
                          input int sz, input int ox, input int oy,
                          input int eq, input int er, input int ex, input int ey);
        int n;
        bit seen;
        @(posedge clk); #1;
        set_beat(qf, rf, sf, sz, ox, oy);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(posedge clk); #1;
            n++;
            bus.valid_in = 1'b0;
            if (bus.valid_out) seen = 1'b1;
        end
        check({name, "_latency"}, n, 32'd3);
        check({name, "_q"}, 32'(bus.q_i), eq);
        check({name, "_r"}, 32'(bus.r_i), er);
        check({name, "_x"}, bus.x_q16, ex);
        check({name, "_y"}, bus.y_q16, ey);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx, stall, start, cyc;
        bit  first, acc, stale;
        int  bq[6], br[6], bsz[6], box[6], boy[6];

        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        set_beat(0, 0, 0, 0, 0, 0);
        bus.valid_in = 1'b0;
        reset = 1'b1;

        // Reset state
        @(posedge clk); #2;
        check("rst_valid_out", 32'(bus.valid_out), 32'd0);
        check("rst_ready_out", 32'(bus.ready_out), 32'd1);
        check("rst_x", bus.x_q16, 32'd0);
        check("rst_q", 32'(bus.q_i), 32'd0);
        @(posedge clk); #3;
        reset = 1'b0;

        // Directed beats, expected values worked out by hand
        single("axis",     65536, 0, -65536, 65536, 0, 0, 1, 0, 113512, 0);
        single("roundfix", 26214, 19661, -45875, 65536, 0, 0, 1, 0, 113512, 0);
        single("scale",    0, 65536, -65536, 131072, 65536, 0, 0, 1, 179048, 196608);
        single("tie",      32768, -32768, 0, 65536, 0, 0, 1, -1, 56756, -98304);
        single("negsize",  0, 65536, -65536, -65536, 0, 0, 0, 1, -56756, -98304);
        single("sat_pos",  1966080000, 0, -1966080000, 32'h7FFF0000, 0, 0,
               30000, 0, 32'h7FFFFFFF, 0);
        single("sat_neg",  -1966080000, 0, 1966080000, 32'h7FFF0000, 0, 0,
               -30000, 0, 32'h80000000, 0);

        // Backpressure: six beats back to back, ready_in low for 4 cycles at first output
        for (int k = 0; k < 6; k++) begin
            bq[k]  = k * 65536 + 3000;
            br[k]  = -(2 * k) * 65536 - 7000;
            bsz[k] = 65536 + k * 4096;
            box[k] = k * 100;
            boy[k] = -k * 200;
        end
        @(posedge clk); #1;
        idx = 0; stall = 0; first = 1'b0; acc = 1'b0; cyc = 0;
        start = n_out;
        while ((n_out - start) < 6 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (acc) idx++;
            if (!first && bus.valid_out) begin
                first = 1'b1;
                stall = 4;
            end
            bus.ready_in = (stall == 0);
            if (stall > 0) stall--;
            if (idx < 6) set_beat(bq[idx], br[idx], -(bq[idx] + br[idx]), bsz[idx], box[idx], boy[idx]);
            else         bus.valid_in = 1'b0;
            @(negedge clk);
            acc = bus.valid_in && bus.ready_out;
            if (!bus.ready_in) check("bp_ready_out", 32'(bus.ready_out), 32'd0);
        end
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        check("bp_count", n_out - start, 32'd6);
        check("bp_drained", exp_q.size(), 32'd0);

        // Reset with two beats in flight
        @(posedge clk); #1;
        set_beat(65536, 0, -65536, 65536, 0, 0);
        @(posedge clk); #1;
        set_beat(0, 65536, -65536, 65536, 0, 0);
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid_out", 32'(bus.valid_out), 32'd0);
        check("mid_rst_ready_out", 32'(bus.ready_out), 32'd1);
        check("mid_rst_y", bus.y_q16, 32'd0);
        check("mid_rst_r", 32'(bus.r_i), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #3;
        reset = 1'b0;
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.valid_out) stale = 1'b1;
        end
        check("no_stale_beat", 32'(stale), 32'd0);
        single("post_rst", 0, 65536, -65536, 131072, 65536, 0, 0, 1, 179048, 196608);

        @(posedge clk); #1;
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
